// File: rtl/motor_rst_pkg.sv
// Shared definitions for the motor reset sequencer: scheduler state encodings
// and default parameter values.
// Latency: n/a (package). Backpressure: n/a.
// Contents: sched_state_t (ST_IDLE, ST_GAP), DEF_* parameter defaults.
package motor_rst_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_GAP  = 1'b1
   } sched_state_t;

   localparam int DEF_NUM_CH         = 8;
   localparam int DEF_MIN_ASSERT_CYC = 1000;
   localparam int DEF_STAGGER_CYC    = 500;
   localparam int DEF_CW             = 16;

endpackage

// File: rtl/motor_rst_sequencer_if.sv
// Bundle between the reset-request PIO and the driver reset pins.
// Latency: n/a (wires only). Backpressure: none, level-based signals.
// master: PIO side (drives rst_req); slave: sequencer (drives drv_rst_n, pending, busy).
interface motor_rst_sequencer_if
   import motor_rst_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH
);
   logic [NUM_CH-1:0] rst_req;    // 1 = hold motor in reset
   logic [NUM_CH-1:0] drv_rst_n;  // active-low driver reset
   logic [NUM_CH-1:0] pending;    // in reset, request removed, waiting for release
   logic              busy;       // release sequence in progress

   modport master (
      output rst_req,
      input  drv_rst_n,
      input  pending,
      input  busy
   );

   modport slave (
      input  rst_req,
      output drv_rst_n,
      output pending,
      output busy
   );
endinterface

// File: rtl/motor_rst_chan.sv
// One driver reset channel: registered drv_rst_n bit plus minimum-low hold counter.
// Latency: assertion 1 edge after rst_req_i sampled high; release on the edge release_i is high.
// Backpressure: none; release_i is only honoured when the channel is not being requested.
// Ports: clk, reset_n, rst_req_i, release_i -> drv_rst_n_o, elig_o, pending_o.
module motor_rst_chan
   import motor_rst_pkg::*;
#(
   parameter int MIN_ASSERT_CYC = DEF_MIN_ASSERT_CYC,
   parameter int CW             = DEF_CW
) (
   input  logic clk,
   input  logic reset_n,
   input  logic rst_req_i,
   input  logic release_i,
   output logic drv_rst_n_o,
   output logic elig_o,
   output logic pending_o
);

   localparam logic [CW-1:0] HOLD_LOAD = CW'(MIN_ASSERT_CYC - 1);

   logic          drv_q, drv_d;
   logic [CW-1:0] hold_q, hold_d;

   always_comb begin
      drv_d  = drv_q;
      hold_d = hold_q;
      if (hold_q != '0) begin
         hold_d = hold_q - CW'(1);
      end
      if (rst_req_i) begin
         // Assertion always wins over a release in the same cycle.
         drv_d = 1'b0;
         // Only a fresh 1->0 edge restarts the minimum-low window; a request
         // arriving while already held low does not extend it.
         if (drv_q) begin
            hold_d = HOLD_LOAD;
         end
      end else if (release_i) begin
         drv_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drv_q  <= 1'b0;
         hold_q <= HOLD_LOAD;
      end else begin
         drv_q  <= drv_d;
         hold_q <= hold_d;
      end
   end

   assign drv_rst_n_o = drv_q;
   assign pending_o   = ~drv_q & ~rst_req_i;
   assign elig_o      = ~drv_q & ~rst_req_i & (hold_q == '0);

endmodule

// File: rtl/motor_rst_sequencer.sv
// Turns the PIO motor-reset request word into per-driver active-low resets with
// immediate assertion, a guaranteed minimum low time and staggered release.
// Latency: assert 1 edge; release >= MIN_ASSERT_CYC low, releases STAGGER_CYC apart.
// Backpressure: none; releases queue in lowest-index order while busy.
// Ports: clk, reset_n (async, active-low), bus (slave: rst_req in; drv_rst_n, pending, busy out).
module motor_rst_sequencer
   import motor_rst_pkg::*;
#(
   parameter int NUM_CH         = DEF_NUM_CH,
   parameter int MIN_ASSERT_CYC = DEF_MIN_ASSERT_CYC,
   parameter int STAGGER_CYC    = DEF_STAGGER_CYC,
   parameter int CW             = DEF_CW
) (
   input  logic                 clk,
   input  logic                 reset_n,
   motor_rst_sequencer_if.slave bus
);

   // The release edge itself is the first cycle of the spacing, and the
   // IDLE cycle after the gap expires is the last, hence the -2.
   localparam logic [CW-1:0] GAP_LOAD = (STAGGER_CYC > 1) ? CW'(STAGGER_CYC - 2) : '0;

   logic [NUM_CH-1:0] elig;
   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] drv;
   logic [NUM_CH-1:0] release_sel;

   sched_state_t  state_q, state_d;
   logic [CW-1:0] gap_q, gap_d;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      motor_rst_chan #(
         .MIN_ASSERT_CYC (MIN_ASSERT_CYC),
         .CW             (CW)
      ) u_chan (
         .clk         (clk),
         .reset_n     (reset_n),
         .rst_req_i   (bus.rst_req[i]),
         .release_i   (release_sel[i]),
         .drv_rst_n_o (drv[i]),
         .elig_o      (elig[i]),
         .pending_o   (pend[i])
      );
   end

   always_comb begin
      release_sel = '0;
      state_d     = state_q;
      gap_d       = gap_q;
      case (state_q)
         ST_IDLE: begin
            if (|elig) begin
               // Isolate the lowest set bit: x & -x.
               release_sel = elig & (~elig + NUM_CH'(1));
               if (STAGGER_CYC > 1) begin
                  state_d = ST_GAP;
                  gap_d   = GAP_LOAD;
               end
            end
         end
         ST_GAP: begin
            if (gap_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
      end
   end

   assign bus.drv_rst_n = drv;
   assign bus.pending   = pend;
   assign bus.busy      = (|pend) | (state_q == ST_GAP);

endmodule

// File: tb/tb_motor_rst_sequencer.sv
// Self-checking bench for motor_rst_sequencer with MIN_ASSERT_CYC=8, STAGGER_CYC=4.
// Directed table rows carry hand-derived expectations; every cycle is also
// compared against a timestamp-based reference model.
module tb_motor_rst_sequencer;

   localparam int NCH  = 8;
   localparam int MIN  = 8;
   localparam int STAG = 4;

   logic clk;
   logic reset_n;

   motor_rst_sequencer_if #(.NUM_CH(NCH)) bus();

   motor_rst_sequencer #(
      .NUM_CH         (NCH),
      .MIN_ASSERT_CYC (MIN),
      .STAGGER_CYC    (STAG),
      .CW             (16)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] req;
      int         cycles;
      logic [7:0] exp_drv;
      logic [7:0] exp_pend;
      logic       exp_busy;
   } vec_t;

   vec_t pon_tbl[12];
   vec_t main_tbl[17];

   int n_vec;
   int n_bad;

   // Reference model: edge index since reset, edge of last 1->0 per channel,
   // edge of last release.
   logic [7:0] cur_req;
   logic [7:0] m_drv;
   int         m_n;
   int         m_aedge[NCH];
   int         m_lastrel;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", name, act, exp, m_n, $time);
      end
   endtask

   task automatic model_reset();
      m_n       = 0;
      m_drv     = '0;
      m_lastrel = -1000;
      for (int i = 0; i < NCH; i++) m_aedge[i] = 0;
   endtask

   task automatic model_edge(input logic [7:0] req);
      logic [7:0] nxt;
      m_n++;
      nxt = m_drv;
      for (int i = 0; i < NCH; i++) begin
         if (req[i]) begin
            if (m_drv[i]) m_aedge[i] = m_n;
            nxt[i] = 1'b0;
         end
      end
      if (m_n - m_lastrel >= STAG) begin
         for (int i = 0; i < NCH; i++) begin
            if (!m_drv[i] && !req[i] && (m_n - m_aedge[i] >= MIN) && (m_lastrel != m_n)) begin
               nxt[i]    = 1'b1;
               m_lastrel = m_n;
            end
         end
      end
      m_drv = nxt;
   endtask

   task automatic model_check();
      logic [7:0] e_pend;
      logic       e_busy;
      e_pend = ~m_drv & ~cur_req;
      e_busy = (|e_pend) || (m_n - m_lastrel <= STAG - 2);
      chk("drv_rst_n", bus.drv_rst_n, m_drv);
      chk("pending", bus.pending, e_pend);
      chk("busy", {7'd0, bus.busy}, {7'd0, e_busy});
   endtask

   // Called just after a posedge (or at time 0): drive, step one edge, check.
   task automatic cycle(input logic [7:0] req);
      cur_req     = req;
      bus.rst_req = req;
      @(posedge clk);
      model_edge(req);
      #1;
      model_check();
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      for (int c = 0; c < v.cycles; c++) cycle(v.req);
      chk({tag, "_drv"}, bus.drv_rst_n, v.exp_drv);
      chk({tag, "_pend"}, bus.pending, v.exp_pend);
      chk({tag, "_busy"}, {7'd0, bus.busy}, {7'd0, v.exp_busy});
   endtask

   // Assert reset asynchronously, check outputs, release on a falling edge.
   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_drv", bus.drv_rst_n, 8'h00);
      chk("rst_pend", bus.pending, ~cur_req);
      chk("rst_busy", {7'd0, bus.busy}, {7'd0, (cur_req != 8'hFF)});
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   function automatic vec_t mk(input logic [7:0] r, input int c, input logic [7:0] d,
                               input logic [7:0] p, input logic b);
      vec_t v;
      v.req = r; v.cycles = c; v.exp_drv = d; v.exp_pend = p; v.exp_busy = b;
      return v;
   endfunction

   initial begin
      // Power-on staircase: ch0 at edge 8, then every 4 edges, idle after edge 39.
      pon_tbl[0]  = mk(8'h00, 7, 8'h00, 8'hFF, 1'b1);
      pon_tbl[1]  = mk(8'h00, 1, 8'h01, 8'hFE, 1'b1);
      pon_tbl[2]  = mk(8'h00, 3, 8'h01, 8'hFE, 1'b1);
      pon_tbl[3]  = mk(8'h00, 1, 8'h03, 8'hFC, 1'b1);
      pon_tbl[4]  = mk(8'h00, 4, 8'h07, 8'hF8, 1'b1);
      pon_tbl[5]  = mk(8'h00, 4, 8'h0F, 8'hF0, 1'b1);
      pon_tbl[6]  = mk(8'h00, 4, 8'h1F, 8'hE0, 1'b1);
      pon_tbl[7]  = mk(8'h00, 4, 8'h3F, 8'hC0, 1'b1);
      pon_tbl[8]  = mk(8'h00, 4, 8'h7F, 8'h80, 1'b1);
      pon_tbl[9]  = mk(8'h00, 4, 8'hFF, 8'h00, 1'b1);
      pon_tbl[10] = mk(8'h00, 2, 8'hFF, 8'h00, 1'b1);
      pon_tbl[11] = mk(8'h00, 1, 8'hFF, 8'h00, 1'b0);

      // One-cycle pulse on ch2: low for exactly 8 edges.
      main_tbl[0]  = mk(8'h04, 1, 8'hFB, 8'h00, 1'b0);
      main_tbl[1]  = mk(8'h00, 7, 8'hFB, 8'h04, 1'b1);
      main_tbl[2]  = mk(8'h00, 1, 8'hFF, 8'h00, 1'b1);
      main_tbl[3]  = mk(8'h00, 3, 8'hFF, 8'h00, 1'b0);
      // ch3 and ch5 together; ch5 re-requested during the gap after ch3.
      main_tbl[4]  = mk(8'h28, 1, 8'hD7, 8'h00, 1'b0);
      main_tbl[5]  = mk(8'h00, 7, 8'hD7, 8'h28, 1'b1);
      main_tbl[6]  = mk(8'h00, 1, 8'hDF, 8'h20, 1'b1);
      main_tbl[7]  = mk(8'h20, 2, 8'hDF, 8'h00, 1'b1);
      main_tbl[8]  = mk(8'h00, 1, 8'hDF, 8'h20, 1'b1);
      main_tbl[9]  = mk(8'h00, 1, 8'hFF, 8'h00, 1'b1);
      main_tbl[10] = mk(8'h00, 3, 8'hFF, 8'h00, 1'b0);
      // All held, then dropped: releases start on the next edge.
      main_tbl[11] = mk(8'hFF, 1, 8'h00, 8'h00, 1'b0);
      main_tbl[12] = mk(8'hFF, 20, 8'h00, 8'h00, 1'b0);
      main_tbl[13] = mk(8'h00, 1, 8'h01, 8'hFE, 1'b1);
      main_tbl[14] = mk(8'h00, 3, 8'h01, 8'hFE, 1'b1);
      main_tbl[15] = mk(8'h00, 1, 8'h03, 8'hFC, 1'b1);
      main_tbl[16] = mk(8'h00, 4, 8'h07, 8'hF8, 1'b1);

      n_vec       = 0;
      n_bad       = 0;
      cur_req     = 8'h00;
      bus.rst_req = 8'h00;
      reset_n     = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();

      foreach (pon_tbl[k]) run_vec(pon_tbl[k], $sformatf("pon%0d", k));
      foreach (main_tbl[k]) run_vec(main_tbl[k], $sformatf("main%0d", k));

      // Reset mid-stagger (three channels out), then the staircase must repeat.
      do_reset();
      foreach (pon_tbl[k]) run_vec(pon_tbl[k], $sformatf("pon2_%0d", k));

      // Randomized traffic against the model, with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         int r;
         logic [7:0] nreq;
         r    = $urandom_range(0, 15);
         nreq = cur_req;
         if (r == 0) nreq = 8'($urandom) & 8'($urandom);
         else if (r < 3) nreq = 8'h00;
         else if (r == 3) nreq = cur_req ^ (8'h01 << $urandom_range(0, 7));
         if ($urandom_range(0, 999) == 0) begin
            cur_req     = nreq;
            bus.rst_req = nreq;
            do_reset();
         end
         cycle(nreq);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
